// File: rtl/sram_arbiter.sv
// Round-robin arbiter that hands the single external asynchronous SRAM to one
// requester at a time and sequences SETUP/ACCESS/DONE strobes on registered pins.
module sram_arbiter #(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0]        i_we_n,
  input  logic [N_REQ*ADDR_W-1:0] i_addr,
  input  logic [N_REQ*DATA_W-1:0] i_wdata,
  output logic [N_REQ-1:0]        o_ack,
  output logic [DATA_W-1:0]       o_rdata,
  output logic                    o_busy,
  output logic [2:0]              o_grant_id,
  output logic [ADDR_W-1:0]       o_sram_addr,
  output logic [DATA_W-1:0]       o_sram_dq,
  output logic                    o_sram_dq_oe,
  input  logic [DATA_W-1:0]       i_sram_dq,
  output logic                    o_sram_we_n,
  output logic                    o_sram_oe_n,
  output logic                    o_sram_ce_n,
  output logic                    o_sram_lb_n,
  output logic                    o_sram_ub_n
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [PTR_W-1:0]   grant, grant_next;
  logic               cur_we_n, cur_we_n_next;

  logic               found;
  logic [PTR_W-1:0]   pick, cand;
  int unsigned        idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_we_n;

  logic [N_REQ-1:0]   ack_next;
  logic [DATA_W-1:0]  rdata_next;
  logic               busy_next;
  logic [2:0]         grant_id_next;
  logic [ADDR_W-1:0]  addr_next;
  logic [DATA_W-1:0]  dq_next;
  logic               dq_oe_next, we_n_next, oe_n_next, ce_n_next;

  // First requesting index at or above rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx  = (int'(rr_ptr) + i) % N_REQ;
      cand = PTR_W'(idx);
      if (!found && i_req[idx]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we_n  = 1'b1;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (PTR_W'(k) == pick) begin
        sel_addr  = i_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = i_wdata[k*DATA_W +: DATA_W];
        sel_we_n  = i_we_n[k];
      end
    end
  end

  // Next-state logic computes the pin values for the state being entered,
  // so every SRAM pin comes straight from a flop.
  always_comb begin
    state_next    = state;
    rr_ptr_next   = rr_ptr;
    cnt_next      = cnt;
    grant_next    = grant;
    cur_we_n_next = cur_we_n;
    ack_next      = '0;
    rdata_next    = o_rdata;
    grant_id_next = o_grant_id;
    addr_next     = o_sram_addr;
    dq_next       = o_sram_dq;
    dq_oe_next    = 1'b0;
    we_n_next     = 1'b1;
    oe_n_next     = 1'b1;
    ce_n_next     = 1'b1;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_next    = SETUP;
          grant_next    = pick;
          grant_id_next = 3'(pick);
          rr_ptr_next   = (pick == PTR_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
          cur_we_n_next = sel_we_n;
          addr_next     = sel_addr;
          dq_next       = sel_wdata;
          dq_oe_next    = ~sel_we_n;
          ce_n_next     = 1'b0;
        end
      end
      SETUP: begin
        state_next = ACCESS;
        cnt_next   = '0;
        ce_n_next  = 1'b0;
        dq_oe_next = ~cur_we_n;
        we_n_next  = cur_we_n;
        oe_n_next  = ~cur_we_n;
      end
      ACCESS: begin
        if (cnt == CNT_W'(ACCESS_CYCLES - 1)) begin
          state_next = DONE;
          ack_next   = N_REQ'(1) << grant;
          if (cur_we_n) rdata_next = i_sram_dq;
        end else begin
          cnt_next   = cnt + 1'b1;
          ce_n_next  = 1'b0;
          dq_oe_next = ~cur_we_n;
          we_n_next  = cur_we_n;
          oe_n_next  = ~cur_we_n;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cnt          <= '0;
      grant        <= '0;
      cur_we_n     <= 1'b1;
      o_ack        <= '0;
      o_rdata      <= '0;
      o_busy       <= 1'b0;
      o_grant_id   <= '0;
      o_sram_addr  <= '0;
      o_sram_dq    <= '0;
      o_sram_dq_oe <= 1'b0;
      o_sram_we_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      o_sram_ce_n  <= 1'b1;
      o_sram_lb_n  <= 1'b1;
      o_sram_ub_n  <= 1'b1;
    end else begin
      state        <= state_next;
      rr_ptr       <= rr_ptr_next;
      cnt          <= cnt_next;
      grant        <= grant_next;
      cur_we_n     <= cur_we_n_next;
      o_ack        <= ack_next;
      o_rdata      <= rdata_next;
      o_busy       <= busy_next;
      o_grant_id   <= grant_id_next;
      o_sram_addr  <= addr_next;
      o_sram_dq    <= dq_next;
      o_sram_dq_oe <= dq_oe_next;
      o_sram_we_n  <= we_n_next;
      o_sram_oe_n  <= oe_n_next;
      o_sram_ce_n  <= ce_n_next;
      o_sram_lb_n  <= ce_n_next;
      o_sram_ub_n  <= ce_n_next;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM and an ack scoreboard.
module tb_sram_arbiter;
  localparam int N = 2, AW = 20, DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, we_n, ack;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, dq_out, dq_in;
  logic            busy, dq_oe, s_we_n, s_oe_n, s_ce_n, s_lb_n, s_ub_n;
  logic [2:0]      grant_id;
  logic [AW-1:0]   s_addr;

  sram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we_n(we_n), .i_addr(addr),
    .i_wdata(wdata), .o_ack(ack), .o_rdata(rdata), .o_busy(busy),
    .o_grant_id(grant_id), .o_sram_addr(s_addr), .o_sram_dq(dq_out),
    .o_sram_dq_oe(dq_oe), .i_sram_dq(dq_in), .o_sram_we_n(s_we_n),
    .o_sram_oe_n(s_oe_n), .o_sram_ce_n(s_ce_n), .o_sram_lb_n(s_lb_n),
    .o_sram_ub_n(s_ub_n)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:4095];
  assign dq_in = (!s_ce_n && !s_oe_n) ? mem[s_addr[11:0]] : 16'hDEAD;
  always @(posedge clk) if (!s_ce_n && !s_we_n && dq_oe) mem[s_addr[11:0]] <= dq_out;

  typedef struct { int id; bit rd; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];
  int nerr = 0, nchk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack !== '0) begin
      if (sb.size() == 0) chk("unexpected_ack", 32'(ack), 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_id", 32'(ack), 32'(1 << e.id));
        if (e.rd) chk("sb_rdata", 32'(rdata), 32'(e.data));
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic wait_ack(output int cyc);
    cyc = 1;
    tick();
    while (ack == '0 && cyc < 20) begin tick(); cyc++; end
    chk("ack_timeout", 32'(ack != '0), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
  endtask

  function automatic exp_t mk(int id, bit rd, logic [DW-1:0] d);
    exp_t e; e.id = id; e.rd = rd; e.data = d; return e;
  endfunction

  int cyc;

  initial begin
    req = '0; we_n = '1; addr = '0; wdata = '0;
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_ce_n", 32'(s_ce_n), 1);
    chk("rst_we_n", 32'(s_we_n), 1);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_grant", 32'(grant_id), 0);

    // Req0 write 0x1234 -> 0x00100, stepped cycle by cycle
    req = 2'b01; we_n = 2'b10; addr[0 +: AW] = 20'h00100; wdata[0 +: DW] = 16'h1234;
    sb.push_back(mk(0, 0, '0));
    tick();
    chk("w_setup_addr", 32'(s_addr), 32'h00100);
    chk("w_setup_dq", 32'(dq_out), 32'h1234);
    chk("w_setup_oe", 32'(dq_oe), 1);
    chk("w_setup_we", 32'(s_we_n), 1);
    chk("w_setup_ce", 32'(s_ce_n), 0);
    chk("w_setup_busy", 32'(busy), 1);
    tick();
    chk("w_acc1_we", 32'(s_we_n), 0);
    chk("w_acc1_busy", 32'(busy), 1);
    tick();
    chk("w_acc2_we", 32'(s_we_n), 0);
    chk("w_acc2_dq", 32'(dq_out), 32'h1234);
    tick();
    chk("w_done_ack", 32'(ack), 1);
    chk("w_done_we", 32'(s_we_n), 1);
    chk("w_done_ce", 32'(s_ce_n), 1);
    chk("w_done_dqoe", 32'(dq_oe), 0);
    chk("w_done_busy", 32'(busy), 1);
    req = '0;
    tick();
    chk("w_idle_busy", 32'(busy), 0);
    chk("w_idle_ack", 32'(ack), 0);

    // Req1 read 0x00100
    req = 2'b10; addr[AW +: AW] = 20'h00100;
    sb.push_back(mk(1, 1, 16'h1234));
    tick();
    chk("r_setup_oe_n", 32'(s_oe_n), 1);
    chk("r_setup_dqoe", 32'(dq_oe), 0);
    tick();
    chk("r_acc1_oe_n", 32'(s_oe_n), 0);
    chk("r_acc1_dqoe", 32'(dq_oe), 0);
    tick();
    chk("r_acc2_oe_n", 32'(s_oe_n), 0);
    tick();
    chk("r_done_ack", 32'(ack), 2);
    chk("r_done_rdata", 32'(rdata), 32'h1234);
    req = '0;
    tick();

    // A later write must not disturb o_rdata
    req = 2'b01; addr[0 +: AW] = 20'h00200; wdata[0 +: DW] = 16'h5678;
    sb.push_back(mk(0, 0, '0));
    wait_ack(cyc);
    chk("w2_latency", 32'(cyc), 4);
    req = '0;
    tick();
    chk("rdata_hold", 32'(rdata), 32'h1234);

    // Simultaneous requests after reset
    do_reset();
    req = 2'b11; we_n = 2'b10;
    addr[0 +: AW] = 20'h00300; wdata[0 +: DW] = 16'hAAAA; addr[AW +: AW] = 20'h00100;
    sb.push_back(mk(0, 0, '0));
    sb.push_back(mk(1, 1, 16'h1234));
    wait_ack(cyc);
    chk("sim_first_grant", 32'(grant_id), 0);
    req[0] = 1'b0;
    wait_ack(cyc);
    chk("sim_spacing", 32'(cyc), 5);
    chk("sim_second_grant", 32'(grant_id), 1);
    req = '0;
    tick();

    // Both held continuously: strict alternation
    req = 2'b11; we_n = 2'b11; addr[0 +: AW] = 20'h00300; addr[AW +: AW] = 20'h00100;
    for (int k = 0; k < 4; k++) sb.push_back(mk(k % 2, 1, (k % 2) ? 16'h1234 : 16'hAAAA));
    for (int k = 0; k < 4; k++) begin
      wait_ack(cyc);
      chk("rr_ack", 32'(ack), (k % 2) ? 2 : 1);
    end
    req = '0;
    tick();

    // Address/data changes after grant are ignored
    req = 2'b01; we_n = 2'b10; addr[0 +: AW] = 20'h00010; wdata[0 +: DW] = 16'h0BEE;
    sb.push_back(mk(0, 0, '0));
    tick();
    addr[0 +: AW] = 20'h00020; wdata[0 +: DW] = 16'hFFFF; we_n[0] = 1'b1;
    chk("lat_setup_addr", 32'(s_addr), 32'h00010);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("lat_acc_addr", 32'(s_addr), 32'h00010);
      chk("lat_acc_dq", 32'(dq_out), 32'h0BEE);
      chk("lat_acc_we", 32'(s_we_n), 0);
    end
    tick();
    chk("lat_done_addr", 32'(s_addr), 32'h00010);
    chk("lat_done_ack", 32'(ack), 1);
    req = '0;
    tick();

    // Reset in the middle of a write ACCESS
    req = 2'b01; we_n = 2'b10; addr[0 +: AW] = 20'h00040; wdata[0 +: DW] = 16'h1111;
    tick(); tick();
    chk("pre_rst_we", 32'(s_we_n), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(s_we_n), 1);
    chk("mid_rst_ce", 32'(s_ce_n), 1);
    chk("mid_rst_oe", 32'(s_oe_n), 1);
    chk("mid_rst_dqoe", 32'(dq_oe), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    req = '0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("no_ack_after_rst", 32'(ack), 0);

    // Service resumes normally: read back the latched-data write
    req = 2'b10; we_n = 2'b11; addr[AW +: AW] = 20'h00010;
    sb.push_back(mk(1, 1, 16'h0BEE));
    wait_ack(cyc);
    chk("post_rst_latency", 32'(cyc), 4);
    req = '0;
    tick(); tick();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
